// File: rtl/imem_responder.sv
// imem_responder: memory side of the I-cache refill port.
// Two-deep request FIFO feeding a fixed-latency fetch FSM over a preloadable word array.
module imem_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           mem_req_valid,
   input  logic [31:0]                    mem_req_addr,
   output logic                           mem_req_ready,
   output logic                           mem_resp_valid,
   output logic [31:0]                    mem_resp_data,
   output logic                           mem_resp_err,
   output logic                           req_drop,
   input  logic                           load_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
   input  logic [31:0]                    load_data
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [31:0] r_cur_addr;
   logic [31:0] r_q [2];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;
   logic        r_drop;
   logic        r_resp_valid;
   logic [31:0] r_resp_data;
   logic        r_resp_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic        w_push;
   logic        w_pop;
   logic        w_not_empty;
   logic        w_err;
   logic [29:0] w_idx;
   logic [31:0] w_rd_word;

   assign mem_req_ready  = (r_count != 2'd2);
   assign w_not_empty    = (r_count != 2'd0);
   assign w_push         = mem_req_valid && mem_req_ready;
   assign w_pop          = w_not_empty && ((r_state == S_IDLE) || (r_state == S_RESP));

   // Full 30-bit index is range-checked so out-of-range addresses never alias into the array.
   assign w_idx          = r_cur_addr[31:2];
   assign w_err          = (r_cur_addr[1:0] != 2'b00) || ({2'b00, w_idx} >= 32'(DEPTH_WORDS));
   assign w_rd_word      = r_mem[w_idx[AW-1:0]];

   assign mem_resp_valid = r_resp_valid;
   assign mem_resp_data  = r_resp_data;
   assign mem_resp_err   = r_resp_err;
   assign req_drop       = r_drop;

   // Request FIFO bookkeeping and the sticky overflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_q[0]   <= 32'd0;
         r_q[1]   <= 32'd0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
         r_drop   <= 1'b0;
      end else begin
         if (w_push) begin
            r_q[r_wr_ptr] <= mem_req_addr;
            r_wr_ptr      <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
         if (mem_req_valid && !mem_req_ready) begin
            r_drop <= 1'b1;
         end
      end
   end

   // Fetch FSM; response data/err are only rewritten on the WAIT->RESP edge so they stay held.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= 4'd0;
         r_cur_addr   <= 32'd0;
         r_resp_valid <= 1'b0;
         r_resp_data  <= 32'd0;
         r_resp_err   <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_not_empty) begin
                  r_cur_addr <= r_q[r_rd_ptr];
                  r_cnt      <= 4'(LATENCY - 1);
                  r_state    <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (r_cnt == 4'd0) begin
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= w_err;
                  r_resp_data  <= w_err ? 32'd0 : w_rd_word;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               if (w_not_empty) begin
                  r_cur_addr <= r_q[r_rd_ptr];
                  r_cnt      <= 4'(LATENCY - 1);
                  r_state    <= S_WAIT;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Backing array: not reset, preload may land in any state and reads return the pre-write word.
   always_ff @(posedge clk) begin
      if (load_en) begin
         r_mem[load_addr] <= load_data;
      end
   end

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder against a timing/ordering reference model.
module tb_imem_responder;

   localparam int DEPTH = 1024;
   localparam int LAT   = 4;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          mem_req_valid = 1'b0;
   logic [31:0]   mem_req_addr = 32'd0;
   logic          mem_req_ready;
   logic          mem_resp_valid;
   logic [31:0]   mem_resp_data;
   logic          mem_resp_err;
   logic          req_drop;
   logic          load_en = 1'b0;
   logic [AW-1:0] load_addr = '0;
   logic [31:0]   load_data = 32'd0;

   imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
      .clk            (clk),
      .reset          (reset),
      .mem_req_valid  (mem_req_valid),
      .mem_req_addr   (mem_req_addr),
      .mem_req_ready  (mem_req_ready),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .req_drop       (req_drop),
      .load_en        (load_en),
      .load_addr      (load_addr),
      .load_data      (load_data)
   );

   always #5 clk = ~clk;

   // s = edge the request leaves the queue, r = edge its response is latched.
   typedef struct {
      int          s;
      int          r;
      logic [31:0] addr;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] ref_mem [DEPTH];
   int          cyc = 0;
   int          last_r = -100;
   bit          model_drop = 1'b0;
   int          n_tests = 0;
   int          n_fail = 0;

   function automatic bit addr_err(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
   endfunction

   function automatic bit model_ready();
      int pend = 0;
      foreach (exp_q[i]) if (exp_q[i].s > cyc) pend++;
      return pend < 2;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      last_r     = -100;
      model_drop = 1'b0;
   endtask

   // One clock edge: the model resolves latches (read before preload), accepts or drops, then #1.
   task automatic tick();
      int          pend;
      exp_t        e;
      logic [31:0] a;
      @(posedge clk);
      cyc++;
      if (!reset) begin
         foreach (exp_q[i]) begin
            if (exp_q[i].r == cyc) begin
               a = exp_q[i].addr;
               exp_q[i].data = exp_q[i].err ? 32'd0 : ref_mem[a[AW+1:2]];
            end
         end
         if (load_en) ref_mem[load_addr] = load_data;
         if (mem_req_valid) begin
            pend = 0;
            foreach (exp_q[i]) if (exp_q[i].s >= cyc) pend++;
            if (pend < 2) begin
               e.s    = (cyc + 1 > last_r + 1) ? cyc + 1 : last_r + 1;
               e.r    = e.s + LAT;
               e.addr = mem_req_addr;
               e.err  = addr_err(mem_req_addr);
               e.data = 32'd0;
               last_r = e.r;
               exp_q.push_back(e);
            end else begin
               model_drop = 1'b1;
            end
         end
      end else if (load_en) begin
         ref_mem[load_addr] = load_data;
      end
      #1;
   endtask

   task automatic req(input logic [31:0] a);
      mem_req_valid = 1'b1;
      mem_req_addr  = a;
      tick();
      mem_req_valid = 1'b0;
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = AW'(idx);
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   task automatic wait_pulse(input int budget, output bit seen);
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         tick();
         seen = mem_resp_valid;
      end
   endtask

   task automatic pop_exp(output exp_t e);
      if (exp_q.size() != 0) e = exp_q.pop_front();
      else begin
         e.s = -1; e.r = -1; e.addr = 32'd0; e.data = 32'hBAD0_BAD0; e.err = 1'b1;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      n_tests++;
      if (mem_resp_valid !== 1'b0 || mem_resp_data !== 32'd0 || mem_resp_err !== 1'b0 ||
          req_drop !== 1'b0 || mem_req_ready !== 1'b1)
         begin n_fail++; $display("FAIL reset_state: valid=%b data=%h err=%b drop=%b ready=%b, want 0/0/0/0/1",
            mem_resp_valid, mem_resp_data, mem_resp_err, req_drop, mem_req_ready); end
      tick();
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_basic();
      exp_t e;
      bit   seen;
      int   acc;
      preload(5, 32'hDEADBEEF);
      req(32'h14);
      acc = cyc;
      wait_pulse(4 * LAT + 8, seen);
      pop_exp(e);
      n_tests++;
      if (!seen || cyc != acc + LAT + 1 || cyc != e.r)
         begin n_fail++; $display("FAIL basic_latency: pulse seen=%0b at edge %0d, want edge %0d", seen, cyc, acc + LAT + 1); end
      n_tests++;
      if (mem_resp_data !== 32'hDEADBEEF || mem_resp_err !== 1'b0)
         begin n_fail++; $display("FAIL basic_data: got %h err=%b, want deadbeef err=0", mem_resp_data, mem_resp_err); end
      tick();
      n_tests++;
      if (mem_resp_valid !== 1'b0 || mem_resp_data !== 32'hDEADBEEF || mem_resp_err !== 1'b0)
         begin n_fail++; $display("FAIL basic_hold: valid=%b data=%h err=%b, want 0/deadbeef/0", mem_resp_valid, mem_resp_data, mem_resp_err); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] want [3];
      exp_t        e;
      bit          seen;
      int          prev;
      want[0] = 32'd11; want[1] = 32'd22; want[2] = 32'd33;
      for (int i = 0; i < 3; i++) preload(i, want[i]);
      req(32'h0);
      req(32'h4);
      n_tests++;
      if (mem_req_ready !== model_ready())
         begin n_fail++; $display("FAIL b2b_ready_before: got %b want %b", mem_req_ready, model_ready()); end
      req(32'h8);
      n_tests++;
      if (mem_req_ready !== model_ready() || mem_req_ready !== 1'b0)
         begin n_fail++; $display("FAIL b2b_ready_full: got %b want 0", mem_req_ready); end
      prev = 0;
      for (int i = 0; i < 3; i++) begin
         wait_pulse(3 * (LAT + 1) + 4, seen);
         pop_exp(e);
         n_tests++;
         if (!seen || cyc != e.r || mem_resp_data !== want[i] || mem_resp_data !== e.data || mem_resp_err !== 1'b0)
            begin n_fail++; $display("FAIL b2b_resp%0d: seen=%0b edge %0d data %h, want edge %0d data %h", i, seen, cyc, mem_resp_data, e.r, want[i]); end
         if (i > 0) begin
            n_tests++;
            if (cyc - prev != LAT + 1)
               begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d cycles want %0d", i, cyc - prev, LAT + 1); end
         end
         prev = cyc;
      end
   endtask

   task automatic test_overflow();
      exp_t e;
      int   n_p;
      for (int i = 16; i < 20; i++) preload(i, $urandom);
      req(32'd64);
      tick();
      req(32'd68);
      req(32'd72);
      req(32'd76);
      n_tests++;
      if (req_drop !== model_drop || req_drop !== 1'b1)
         begin n_fail++; $display("FAIL ovf_drop: got %b want 1", req_drop); end
      n_tests++;
      if (mem_req_ready !== model_ready())
         begin n_fail++; $display("FAIL ovf_ready: got %b want %b", mem_req_ready, model_ready()); end
      n_p = 0;
      repeat (4 * (LAT + 1) + 8) begin
         tick();
         if (mem_resp_valid) begin
            n_p++;
            pop_exp(e);
            n_tests++;
            if (cyc != e.r || mem_resp_data !== e.data || mem_resp_err !== e.err)
               begin n_fail++; $display("FAIL ovf_resp: edge %0d data %h, want edge %0d data %h", cyc, mem_resp_data, e.r, e.data); end
         end
      end
      n_tests++;
      if (n_p != 3)
         begin n_fail++; $display("FAIL ovf_count: got %0d responses want 3", n_p); end
   endtask

   task automatic test_errors();
      logic [31:0] addrs [5];
      logic        errs  [5];
      exp_t        e;
      bit          seen;
      addrs[0] = 32'h2;             errs[0] = 1'b1;
      addrs[1] = 32'(DEPTH * 4);    errs[1] = 1'b1;
      addrs[2] = 32'((DEPTH - 1) * 4); errs[2] = 1'b0;
      addrs[3] = 32'hFFFF_FFFC;     errs[3] = 1'b1;
      addrs[4] = 32'h0000_1001;     errs[4] = 1'b1;
      preload(DEPTH - 1, $urandom | 32'h1);
      for (int i = 0; i < 5; i++) begin
         req(addrs[i]);
         wait_pulse(4 * LAT + 8, seen);
         pop_exp(e);
         n_tests++;
         if (!seen || cyc != e.r || mem_resp_err !== errs[i] || mem_resp_data !== e.data ||
             (errs[i] && mem_resp_data !== 32'd0))
            begin n_fail++; $display("FAIL err_addr%0d: addr %h seen=%0b err=%b data=%h, want err=%b data=%h", i, addrs[i], seen, mem_resp_err, mem_resp_data, errs[i], e.data); end
      end
   endtask

   task automatic test_collision();
      logic [31:0] a_val;
      logic [31:0] b_val;
      exp_t        e;
      bit          seen;
      int          r_edge;
      a_val = $urandom;
      b_val = ~a_val;
      preload(3, a_val);
      req(32'hC);
      r_edge = (exp_q.size() != 0) ? exp_q[0].r : cyc + LAT + 1;
      while (cyc < r_edge - 1) tick();
      load_en   = 1'b1;
      load_addr = AW'(3);
      load_data = b_val;
      tick();
      load_en   = 1'b0;
      pop_exp(e);
      n_tests++;
      if (mem_resp_valid !== 1'b1 || mem_resp_data !== a_val || mem_resp_data !== e.data)
         begin n_fail++; $display("FAIL collide_old: valid=%b data=%h, want 1/%h", mem_resp_valid, mem_resp_data, a_val); end
      req(32'hC);
      wait_pulse(4 * LAT + 8, seen);
      pop_exp(e);
      n_tests++;
      if (!seen || mem_resp_data !== b_val || cyc != e.r)
         begin n_fail++; $display("FAIL collide_new: seen=%0b data=%h, want %h", seen, mem_resp_data, b_val); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] w;
      exp_t        e;
      bit          seen;
      int          acc;
      int          n_p;
      w = $urandom;
      preload(7, w);
      req(32'd28);
      tick();
      tick();
      reset = 1'b1;
      #1;
      n_tests++;
      if (mem_resp_valid !== 1'b0 || mem_resp_data !== 32'd0 || mem_resp_err !== 1'b0 ||
          req_drop !== 1'b0 || mem_req_ready !== 1'b1)
         begin n_fail++; $display("FAIL midreset_state: valid=%b data=%h err=%b drop=%b ready=%b, want 0/0/0/0/1",
            mem_resp_valid, mem_resp_data, mem_resp_err, req_drop, mem_req_ready); end
      model_reset();
      tick();
      reset = 1'b0;
      n_p = 0;
      repeat (LAT + 4) begin
         tick();
         if (mem_resp_valid) n_p++;
      end
      n_tests++;
      if (n_p != 0)
         begin n_fail++; $display("FAIL midreset_ghost: got %0d responses want 0", n_p); end
      req(32'd28);
      acc = cyc;
      wait_pulse(4 * LAT + 8, seen);
      pop_exp(e);
      n_tests++;
      if (!seen || cyc != acc + LAT + 1 || mem_resp_data !== w || mem_resp_err !== 1'b0)
         begin n_fail++; $display("FAIL midreset_fresh: seen=%0b edge %0d data %h, want edge %0d data %h", seen, cyc, mem_resp_data, acc + LAT + 1, w); end
   endtask

   task automatic test_random();
      exp_t e;
      bit   exp_v;
      int   sel;
      for (int i = 0; i < 16; i++) preload(i, $urandom);
      for (int k = 0; k < 330; k++) begin
         mem_req_valid = (k < 300) && ($urandom_range(0, 2) == 0);
         sel = $urandom_range(0, 9);
         if (sel == 0)      mem_req_addr = {26'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(1, 3))};
         else if (sel == 1) mem_req_addr = 32'(DEPTH * 4) + {20'd0, 10'($urandom), 2'b00};
         else               mem_req_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         load_en   = ($urandom_range(0, 5) == 0);
         load_addr = AW'($urandom_range(0, 15));
         load_data = $urandom;
         tick();
         exp_v = (exp_q.size() != 0) && (exp_q[0].r == cyc);
         n_tests++;
         if (mem_resp_valid !== exp_v)
            begin n_fail++; $display("FAIL rnd_valid: edge %0d got %b want %b", cyc, mem_resp_valid, exp_v); end
         if (exp_v) begin
            pop_exp(e);
            n_tests++;
            if (mem_resp_data !== e.data || mem_resp_err !== e.err)
               begin n_fail++; $display("FAIL rnd_resp: addr %h got %h/%b want %h/%b", e.addr, mem_resp_data, mem_resp_err, e.data, e.err); end
         end
         n_tests++;
         if (mem_req_ready !== model_ready())
            begin n_fail++; $display("FAIL rnd_ready: edge %0d got %b want %b", cyc, mem_req_ready, model_ready()); end
         n_tests++;
         if (req_drop !== model_drop)
            begin n_fail++; $display("FAIL rnd_drop: edge %0d got %b want %b", cyc, req_drop, model_drop); end
      end
      mem_req_valid = 1'b0;
      load_en       = 1'b0;
      n_tests++;
      if (exp_q.size() != 0)
         begin n_fail++; $display("FAIL rnd_drain: %0d responses never arrived", exp_q.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow();
      test_errors();
      test_collision();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
